// File: rtl/bc_branch_resolver.sv
// bc_branch_resolver: resolves B-form conditional branches (opcode 16).
// Evaluates BO/BI against CR and CTR, computes the target, maintains the
// architectural CTR and LR, and presents results through a one-deep output
// register with a stall handshake.
//
// Body layout (big-endian field numbering, body bit k = instructionBody_i[25-k]):
//   BO[0:4] = [25:21], BI = [20:16], BD = [15:2], AA = [1], LK = [0]
//
// Optional feature: define BC_BRANCH_STATS_EN to add saturating taken /
// not-taken counters (takenCount_o, notTakenCount_o).
module bc_branch_resolver #(
    parameter int unsigned addressWidth            = 64,
    parameter int unsigned instructionCounterWidth = 64,
    parameter int unsigned opcodeSize              = 6,
    parameter int unsigned bodySize                = 26,
    parameter int unsigned BranchUnitID            = 6,
    parameter int unsigned funcUnitCodeSize        = 3
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    output logic                               ready_o,
    input  logic [opcodeSize-1:0]              instructionOpcode_i,
    input  logic [funcUnitCodeSize-1:0]        functionalUnitType_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic [instructionCounterWidth-1:0] instMajId_i,
    input  logic                               is64Bit_i,
    input  logic [bodySize-1:0]                instructionBody_i,
    input  logic [31:0]                        cr_i,
    input  logic                               ctrWrite_i,
    input  logic                               lrWrite_i,
    input  logic [63:0]                        sprData_i,
    output logic                               valid_o,
    input  logic                               stall_i,
    output logic                               taken_o,
    output logic [addressWidth-1:0]            target_o,
    output logic [instructionCounterWidth-1:0] majId_o,
    output logic                               illegal_o,
    output logic [63:0]                        ctr_o,
    output logic [63:0]                        lr_o
`ifdef BC_BRANCH_STATS_EN
    ,
    output logic [31:0]                        takenCount_o,
    output logic [31:0]                        notTakenCount_o
`endif
);

    localparam logic [opcodeSize-1:0]       BcOpcode = opcodeSize'(16);
    localparam logic [funcUnitCodeSize-1:0] BrUnit   = funcUnitCodeSize'(BranchUnitID);

    // In 32-bit mode the upper word of an effective address is zero.
    function automatic logic [63:0] mode_mask(input logic [63:0] a, input logic m64);
        return m64 ? a : {32'h0, a[31:0]};
    endfunction

    // Output and architectural state
    logic                               valid_q, valid_d;
    logic                               taken_q, taken_d;
    logic                               illegal_q, illegal_d;
    logic [addressWidth-1:0]            target_q, target_d;
    logic [instructionCounterWidth-1:0] majid_q, majid_d;
    logic [63:0]                        ctr_q, ctr_d;
    logic [63:0]                        lr_q, lr_d;

    // Decoded fields
    logic [4:0]  bo;
    logic [4:0]  bi;
    logic [13:0] bd;
    logic        aa;
    logic        lk;
    logic        unused_hint;

    // Evaluation
    logic        accept;
    logic        legal;
    logic [63:0] cia64;
    logic [63:0] ctr_dec;
    logic [63:0] ctr_dec_m;
    logic        ctr_ok;
    logic        cond_ok;
    logic        br_taken;
    logic [63:0] bd_ext;
    logic [63:0] tgt_raw;
    logic [63:0] seq_raw;
    logic [63:0] next_target;

    assign ready_o = !(valid_q && stall_i);
    assign accept  = enable_i && ready_o;

    // Field extraction; BO[4] is the prediction hint and has no effect here.
    always_comb begin
        bo          = instructionBody_i[25:21];
        bi          = instructionBody_i[20:16];
        bd          = instructionBody_i[15:2];
        aa          = instructionBody_i[1];
        lk          = instructionBody_i[0];
        unused_hint = bo[0];
    end

    // Condition, count and target evaluation against the pre-cycle CTR.
    always_comb begin
        legal     = (instructionOpcode_i == BcOpcode) && (functionalUnitType_i == BrUnit);
        cia64     = 64'(instructionAddress_i);
        ctr_dec   = ctr_q - 64'd1;
        ctr_dec_m = is64Bit_i ? ctr_dec : {32'h0, ctr_dec[31:0]};
        // BO[n] lives at bo[4-n].
        ctr_ok    = bo[2] | ((ctr_dec_m != 64'd0) ^ bo[1]);
        cond_ok   = bo[4] | (cr_i[bi] == bo[3]);
        br_taken  = legal & ctr_ok & cond_ok;
        bd_ext    = {{48{bd[13]}}, bd, 2'b00};
        tgt_raw   = bd_ext + (aa ? 64'd0 : cia64);
        seq_raw   = cia64 + 64'd4;
        next_target = br_taken ? mode_mask(tgt_raw, is64Bit_i)
                               : mode_mask(seq_raw, is64Bit_i);
    end

    // Next-state for CTR/LR: branch updates take priority over sideband writes.
    always_comb begin
        ctr_d = ctr_q;
        lr_d  = lr_q;
        if (ctrWrite_i) begin
            ctr_d = sprData_i;
        end
        if (lrWrite_i) begin
            lr_d = sprData_i;
        end
        if (accept && legal && !bo[2]) begin
            ctr_d = ctr_dec;
        end
        if (accept && legal && lk) begin
            lr_d = seq_raw;
        end
    end

    // Next-state for the one-deep result register; holds while stalled.
    always_comb begin
        valid_d   = valid_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        target_d  = target_q;
        majid_d   = majid_q;
        if (accept) begin
            valid_d   = 1'b1;
            taken_d   = br_taken;
            illegal_d = !legal;
            target_d  = next_target[addressWidth-1:0];
            majid_d   = instMajId_i;
        end else if (ready_o) begin
            valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q   <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            target_q  <= '0;
            majid_q   <= '0;
            ctr_q     <= 64'd0;
            lr_q      <= 64'd0;
        end else begin
            valid_q   <= valid_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            target_q  <= target_d;
            majid_q   <= majid_d;
            ctr_q     <= ctr_d;
            lr_q      <= lr_d;
        end
    end

    assign valid_o   = valid_q;
    assign taken_o   = taken_q;
    assign illegal_o = illegal_q;
    assign target_o  = target_q;
    assign majId_o   = majid_q;
    assign ctr_o     = ctr_q;
    assign lr_o      = lr_q;

`ifdef BC_BRANCH_STATS_EN
    logic [31:0] tcnt_q, tcnt_d;
    logic [31:0] ncnt_q, ncnt_d;

    // Saturating per-outcome counters for legal accepted branches.
    always_comb begin
        tcnt_d = tcnt_q;
        ncnt_d = ncnt_q;
        if (accept && legal) begin
            if (br_taken) begin
                if (tcnt_q != 32'hFFFF_FFFF) tcnt_d = tcnt_q + 32'd1;
            end else begin
                if (ncnt_q != 32'hFFFF_FFFF) ncnt_d = ncnt_q + 32'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            tcnt_q <= 32'd0;
            ncnt_q <= 32'd0;
        end else begin
            tcnt_q <= tcnt_d;
            ncnt_q <= ncnt_d;
        end
    end

    assign takenCount_o    = tcnt_q;
    assign notTakenCount_o = ncnt_q;
`endif

endmodule

// File: tb/tb_bc_branch_resolver.sv
// Scoreboard bench for bc_branch_resolver: directed cases plus random traffic
// checked against a behavioural model of the branch rules.
module tb_bc_branch_resolver;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        ready_o;
    logic [5:0]  opc = 6'd16;
    logic [2:0]  fu = 3'd6;
    logic [63:0] cia = 64'd0;
    logic [63:0] mid = 64'd0;
    logic        is64 = 1'b1;
    logic [4:0]  bo_v = 5'd0;
    logic [4:0]  bi_v = 5'd0;
    logic [13:0] bd_v = 14'd0;
    logic        aa_v = 1'b0;
    logic        lk_v = 1'b0;
    logic [25:0] body;
    logic [31:0] cr = 32'd0;
    logic        ctrw = 1'b0;
    logic        lrw = 1'b0;
    logic [63:0] spr = 64'd0;
    logic        valid_o;
    logic        stall_i = 1'b0;
    logic        taken_o;
    logic [63:0] target_o;
    logic [63:0] majId_o;
    logic        illegal_o;
    logic [63:0] ctr_o;
    logic [63:0] lr_o;
`ifdef BC_BRANCH_STATS_EN
    logic [31:0] takenCount_o;
    logic [31:0] notTakenCount_o;
    int unsigned m_tc = 0;
    int unsigned m_nc = 0;
`endif

    assign body = {bo_v, bi_v, bd_v, aa_v, lk_v};

    always #5 clk = ~clk;

    bc_branch_resolver dut (
        .clock_i              (clk),
        .reset_i              (reset_i),
        .enable_i             (enable_i),
        .ready_o              (ready_o),
        .instructionOpcode_i  (opc),
        .functionalUnitType_i (fu),
        .instructionAddress_i (cia),
        .instMajId_i          (mid),
        .is64Bit_i            (is64),
        .instructionBody_i    (body),
        .cr_i                 (cr),
        .ctrWrite_i           (ctrw),
        .lrWrite_i            (lrw),
        .sprData_i            (spr),
        .valid_o              (valid_o),
        .stall_i              (stall_i),
        .taken_o              (taken_o),
        .target_o             (target_o),
        .majId_o              (majId_o),
        .illegal_o            (illegal_o),
        .ctr_o                (ctr_o),
        .lr_o                 (lr_o)
`ifdef BC_BRANCH_STATS_EN
        ,
        .takenCount_o         (takenCount_o),
        .notTakenCount_o      (notTakenCount_o)
`endif
    );

    typedef struct {
        bit        taken;
        bit        illegal;
        bit [63:0] target;
        bit [63:0] majid;
    } exp_t;

    exp_t        sb[$];
    bit          m_valid = 1'b0;
    bit [63:0]   m_ctr = 64'd0;
    bit [63:0]   m_lr = 64'd0;
    int unsigned total = 0;
    int unsigned bad = 0;
    bit [63:0]   next_id = 64'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    // BO bits are numbered from the most significant end.
    function automatic bit bo_bit(input logic [4:0] b, input int k);
        return b[4-k];
    endfunction

    // Reference model, applied at each rising edge with the inputs that edge saw.
    task automatic model_edge();
        bit        rdy;
        bit [63:0] nctr;
        bit [63:0] nlr;
        bit [63:0] dec;
        bit [63:0] dec_m;
        bit [63:0] tgt;
        bit [63:0] seq;
        longint    off;
        bit        ok_ctr;
        bit        ok_cond;
        bit        tk;
        exp_t      e;
        rdy  = !(m_valid && stall_i);
        nctr = ctrw ? spr : m_ctr;
        nlr  = lrw ? spr : m_lr;
        if (enable_i && rdy) begin
            e.majid = mid;
            if (opc != 6'd16 || fu != 3'd6) begin
                e.taken   = 1'b0;
                e.illegal = 1'b1;
                e.target  = 64'd0;
            end else begin
                dec     = m_ctr - 64'd1;
                dec_m   = is64 ? dec : (dec & 64'hFFFF_FFFF);
                ok_ctr  = bo_bit(bo_v, 2) || ((dec_m != 0) != bo_bit(bo_v, 3));
                ok_cond = bo_bit(bo_v, 0) || (((cr >> bi_v) & 32'd1) == 32'(bo_bit(bo_v, 1)));
                tk      = ok_ctr && ok_cond;
                off     = (bd_v >= 14'd8192) ? (longint'(bd_v) * 4 - 65536) : longint'(bd_v) * 4;
                seq     = cia + 64'd4;
                tgt     = tk ? ((aa_v ? 64'd0 : cia) + 64'(off)) : seq;
                if (!is64) tgt = tgt & 64'hFFFF_FFFF;
                if (!bo_bit(bo_v, 2)) nctr = dec;
                if (lk_v) nlr = seq;
                e.taken   = tk;
                e.illegal = 1'b0;
                e.target  = tgt;
`ifdef BC_BRANCH_STATS_EN
                if (tk) begin
                    if (m_tc != 32'hFFFF_FFFF) m_tc++;
                end else begin
                    if (m_nc != 32'hFFFF_FFFF) m_nc++;
                end
`endif
            end
            sb.push_back(e);
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        m_ctr = nctr;
        m_lr  = nlr;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        enable_i = 1'b0;
        ctrw     = 1'b0;
        lrw      = 1'b0;
        stall_i  = 1'b0;
        opc      = 6'd16;
        fu       = 3'd6;
    endtask

    task automatic branch(input logic [4:0] b, input logic [4:0] i, input logic [13:0] d,
                          input logic a, input logic l, input logic [63:0] addr,
                          input logic m64);
        enable_i = 1'b1;
        opc      = 6'd16;
        fu       = 3'd6;
        bo_v     = b;
        bi_v     = i;
        bd_v     = d;
        aa_v     = a;
        lk_v     = l;
        cia      = addr;
        is64     = m64;
        mid      = next_id;
        next_id  = next_id + 64'd1;
    endtask

    task automatic set_ctr(input logic [63:0] v);
        idle();
        ctrw = 1'b1;
        spr  = v;
        step();
        ctrw = 1'b0;
    endtask

    // Monitor: compares outputs against the model away from the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_i) begin
                chk("valid", 64'(valid_o), 64'(m_valid));
                chk("ready", 64'(ready_o), 64'(!(m_valid && stall_i)));
                chk("ctr", ctr_o, m_ctr);
                chk("lr", lr_o, m_lr);
`ifdef BC_BRANCH_STATS_EN
                chk("taken_count", 64'(takenCount_o), 64'(m_tc));
                chk("nottaken_count", 64'(notTakenCount_o), 64'(m_nc));
`endif
                if (m_valid) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL scoreboard: got empty queue, want an entry");
                    end else begin
                        e = sb[0];
                        if (valid_o) begin
                            chk("taken", 64'(taken_o), 64'(e.taken));
                            chk("illegal", 64'(illegal_o), 64'(e.illegal));
                            chk("majid", majId_o, e.majid);
                            if (!e.illegal) chk("target", target_o, e.target);
                        end
                        if (!stall_i) void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bit [63:0] r;
        // Reset state
        #1;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_ctr", ctr_o, 64'd0);
        chk("rst_target", target_o, 64'd0);
        #11 reset_i = 1'b0;
        step();

        // Branch always with negative displacement
        set_ctr(64'd7);
        branch(5'b10100, 5'd0, 14'h3FFF, 1'b0, 1'b0, 64'h1000, 1'b1);
        step();
        idle();
        chk("d_always_taken", 64'(taken_o), 64'd1);
        chk("d_always_target", target_o, 64'h0FFC);
        chk("d_always_ctr", ctr_o, 64'd7);
        step();

        // bdnz with CTR=1, then CTR=0 (wrap)
        set_ctr(64'd1);
        branch(5'b10000, 5'd0, 14'h0010, 1'b0, 1'b0, 64'h3000, 1'b1);
        step();
        idle();
        chk("d_bdnz1_ctr", ctr_o, 64'd0);
        chk("d_bdnz1_taken", 64'(taken_o), 64'd0);
        chk("d_bdnz1_target", target_o, 64'h3004);
        branch(5'b10000, 5'd0, 14'h0010, 1'b0, 1'b0, 64'h3000, 1'b1);
        step();
        idle();
        chk("d_bdnz0_ctr", ctr_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("d_bdnz0_taken", 64'(taken_o), 64'd1);
        step();

        // Back-to-back bdnz with CTR=2
        set_ctr(64'd2);
        branch(5'b10000, 5'd0, 14'h0020, 1'b0, 1'b0, 64'h4000, 1'b1);
        step();
        chk("d_b2b_first", 64'(taken_o), 64'd1);
        branch(5'b10000, 5'd0, 14'h0020, 1'b0, 1'b0, 64'h4100, 1'b1);
        step();
        idle();
        chk("d_b2b_second", 64'(taken_o), 64'd0);
        chk("d_b2b_ctr", ctr_o, 64'd0);
        step();

        // CR condition with link
        cr = 32'h0000_0020;
        branch(5'b01100, 5'd5, 14'h0040, 1'b0, 1'b1, 64'h2000, 1'b1);
        step();
        idle();
        chk("d_link_lr", lr_o, 64'h2004);
        step();

        // 32-bit mode target wrap
        branch(5'b10100, 5'd0, 14'h0002, 1'b0, 1'b0, 64'hFFFF_FFFC, 1'b0);
        step();
        idle();
        chk("d_m32_target", target_o, 64'h4);
        step();

        // Stall with enable held
        branch(5'b10100, 5'd0, 14'h0100, 1'b0, 1'b0, 64'h5000, 1'b1);
        step();
        branch(5'b10100, 5'd0, 14'h0200, 1'b0, 1'b0, 64'h6000, 1'b1);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("d_stall_ready", 64'(ready_o), 64'd0);
        chk("d_stall_target", target_o, 64'h5400);
        stall_i = 1'b0;
        step();
        idle();
        chk("d_release_target", target_o, 64'h6800);
        step();

        // Same-cycle sideband CTR write and decrementing branch
        set_ctr(64'd9);
        branch(5'b10000, 5'd0, 14'h0004, 1'b0, 1'b0, 64'h7000, 1'b1);
        ctrw = 1'b1;
        spr  = 64'd5;
        step();
        idle();
        chk("d_sideband_ctr", ctr_o, 64'd8);
        step();

        // Illegal opcode
        branch(5'b10000, 5'd0, 14'h0004, 1'b0, 1'b1, 64'h8000, 1'b1);
        opc = 6'd18;
        step();
        idle();
        chk("d_illegal", 64'(illegal_o), 64'd1);
        chk("d_illegal_ctr", ctr_o, 64'd8);
        step();

        // Reset mid-stall
        branch(5'b10100, 5'd0, 14'h0008, 1'b0, 1'b1, 64'h9000, 1'b1);
        step();
        stall_i = 1'b1;
        step();
        #2 reset_i = 1'b1;
        #1;
        chk("r_valid", 64'(valid_o), 64'd0);
        chk("r_taken", 64'(taken_o), 64'd0);
        chk("r_illegal", 64'(illegal_o), 64'd0);
        chk("r_target", target_o, 64'd0);
        chk("r_majid", majId_o, 64'd0);
        chk("r_ctr", ctr_o, 64'd0);
        chk("r_lr", lr_o, 64'd0);
        chk("r_ready", 64'(ready_o), 64'd1);
        sb.delete();
        m_valid = 1'b0;
        m_ctr   = 64'd0;
        m_lr    = 64'd0;
`ifdef BC_BRANCH_STATS_EN
        m_tc = 0;
        m_nc = 0;
`endif
        #2 reset_i = 1'b0;
        idle();
        step();

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            r = {$urandom, $urandom};
            branch(5'($urandom), 5'($urandom), 14'($urandom),
                   ($urandom_range(0, 7) == 0), 1'($urandom),
                   (($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 255)) : r) & ~64'd3,
                   1'($urandom));
            mid      = {$urandom, $urandom};
            enable_i = ($urandom_range(0, 9) < 7);
            opc      = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'd16;
            fu       = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd6;
            cr       = $urandom;
            stall_i  = ($urandom_range(0, 9) < 3);
            ctrw     = ($urandom_range(0, 9) == 0);
            lrw      = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: spr = 64'd0;
                1: spr = 64'd1;
                2: spr = 64'd2;
                default: spr = {$urandom, $urandom};
            endcase
            step();
        end

        idle();
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
